// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule producer: loads 16 words, then streams W[0..63].
// Latency: out_valid rises the cycle after the 16th accept; next block load
//          starts the cycle after the 64th output handshake.
// Backpressure: out_ready=0 freezes W[t], t and out_last; in_ready only in LOAD.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  synchronous abort back to LOAD, window cleared
//   in_valid/in_ready/in_data     32-bit message words, W[0] first
//   out_valid/out_ready/out_data  schedule words W[t]
//   out_last             marks W[63]
//   out_idx              t of the word on out_data (only with MSG_SCHED_IDX_EN)
//
// Build option: define MSG_SCHED_IDX_EN to add the out_idx port.

module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
`ifdef MSG_SCHED_IDX_EN
    ,
    output logic [5:0]  out_idx
`endif
);

    // Block words loaded before emission and schedule words per block.
    localparam int NWORDS  = 16;
    localparam int NROUNDS = 64;

    localparam logic [3:0] COUNT_LAST = 4'(NWORDS - 1);
    localparam logic [5:0] T_LAST     = 6'(NROUNDS - 1);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Small sigma functions of the schedule expansion.
    // ------------------------------------------------------------------
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [5:0]  t_q,     t_d;
    // win_q[0] is always the word currently offered (W[t] in EMIT);
    // win_q[15] is the newest word.
    logic [31:0] win_q [NWORDS];
    logic [31:0] win_d [NWORDS];

    logic [31:0] w_next;
    logic        in_hs;
    logic        out_hs;

    // ------------------------------------------------------------------
    // Register process
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            count_q <= '0;
            t_q     <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            t_q     <= t_d;
            for (int i = 0; i < NWORDS; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Expansion: with win_q holding W[t..t+15], this yields W[t+16].
    // ------------------------------------------------------------------
    always_comb begin
        w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    end

    // ------------------------------------------------------------------
    // Next-state process
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        t_d     = t_q;
        for (int i = 0; i < NWORDS; i++) begin
            win_d[i] = win_q[i];
        end

        in_hs  = (state_q == LOAD) && in_valid;
        out_hs = (state_q == EMIT) && out_ready;

        if (clr) begin
            // Abort wins over any handshake in the same cycle.
            state_d = LOAD;
            count_d = '0;
            t_d     = '0;
            for (int i = 0; i < NWORDS; i++) begin
                win_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_hs) begin
                        for (int i = 0; i < NWORDS - 1; i++) begin
                            win_d[i] = win_q[i + 1];
                        end
                        win_d[NWORDS - 1] = in_data;
                        if (count_q == COUNT_LAST) begin
                            count_d = '0;
                            t_d     = '0;
                            state_d = EMIT;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        for (int i = 0; i < NWORDS - 1; i++) begin
                            win_d[i] = win_q[i + 1];
                        end
                        win_d[NWORDS - 1] = w_next;
                        if (t_q == T_LAST) begin
                            // The window content left behind is fully
                            // overwritten by the next 16-word load.
                            t_d     = '0;
                            count_d = '0;
                            state_d = LOAD;
                        end else begin
                            t_d = t_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output process
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == EMIT);
        out_data  = win_q[0];
        out_last  = (state_q == EMIT) && (t_q == T_LAST);
`ifdef MSG_SCHED_IDX_EN
        out_idx   = (state_q == EMIT) ? t_q : 6'd0;
`endif
    end

endmodule
